uart_tx_arbiter: RTL and testbench
==================================

Name: uart_tx_arbiter

Overview:
- Shares one UART transmitter between NUM_REQ byte sources using round-robin arbitration and a valid/ready handshake per requester.
- Sequences the transmitter through a start-pulse / ready-level protocol.
- Supports packet lock: a requester keeps the grant until it sends a byte marked last.
- Sits between protocol or logging engines and the single uart_tx serializer on the board pin.

Parameters:
- NUM_REQ, 4, number of requesters; legal range 2..16.
- DATA_BITS, 8, width of one UART character; must match the transmitter.
- ACK_TIMEOUT, 16, cycles to wait for tx_ready to drop after tx_start before flagging an error; must be 1..255.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-low reset.
- req_valid  input  NUM_REQ  bit i: requester i has a byte.
- req_data  input  NUM_REQ*DATA_BITS  requester i byte in bits [i*DATA_BITS +: DATA_BITS].
- req_last  input  NUM_REQ  bit i: the offered byte ends requester i's packet.
- req_ready  output  NUM_REQ  one-hot accept strobe; the byte transfers when valid and ready are both high.
- tx_ready  input  1  transmitter idle, level signal.
- tx_start  output  1  one-cycle pulse that launches a character.
- tx_data  output  DATA_BITS  character to send; registered and held stable until the next capture.
- grant_id  output  $clog2(NUM_REQ)  current or last granted requester.
- locked  output  1  grant is held mid-packet.
- err_timeout  output  1  sticky; set when the transmitter failed to acknowledge.

Behaviour:
- Reset (reset==0 at an edge) forces the following. State IDLE. req_ready=0, tx_start=0, tx_data=0, grant_id=0, locked=0, err_timeout=0. Round-robin pointer=NUM_REQ-1, so requester 0 has first priority. Reset mid-transfer abandons the byte; the transmitter is not told.
- States: IDLE, START, WAIT_ACK, WAIT_DONE, LOCKED.
- IDLE
  - When tx_ready==1 and any req_valid is high, select winner w = the first valid index searching upward (with wrap) from pointer+1.
  - req_ready[w]=1 combinationally in this cycle only.
  - At the edge: tx_data<=req_data[w], grant_id<=w, pointer<=w, last_flag<=req_last[w]. Go to START.
  - When tx_ready==0, hold and assert no ready.
- START: tx_start=1 for exactly one cycle. Clear the ack counter. Go to WAIT_ACK.
- WAIT_ACK
  - tx_ready==0 goes to WAIT_DONE.
  - Otherwise increment the counter. If the counter reaches ACK_TIMEOUT: set err_timeout, clear locked, and go to IDLE. The byte is dropped and the pointer keeps w.
- WAIT_DONE
  - On tx_ready==1: if last_flag==1, locked<=0 and go to IDLE. Otherwise locked<=1 and go to LOCKED.
- LOCKED
  - Only requester grant_id is considered; all other req_valid inputs are ignored.
  - When req_valid[grant_id] and tx_ready are both high: req_ready[grant_id]=1, capture exactly as in IDLE, go to START.
  - Waits indefinitely otherwise; there is no lock timeout.
- Throughput: a capture happens at the earliest in the cycle after tx_ready returns high. Minimum per-byte overhead is 2 cycles (capture, START) plus transmitter busy time.
- Latency: tx_start fires 1 cycle after the req_ready cycle.
- At most one req_ready bit is high in any cycle. req_ready is never high outside IDLE/LOCKED.
- Simultaneous events:
  - A requester dropping req_valid while not granted has no effect.
  - req_valid high for every requester gives strict rotation 0,1,2,3,0,...
  - The err_timeout set and an IDLE capture cannot occur in the same cycle.
- err_timeout clears only on reset.
- tx_data does not change except on a capture edge.

Test Plan:
- Single byte: reset 4 cycles low. Requester 2 offers 0xA5 with last=1, tx model drops tx_ready 1 cycle after tx_start and holds it low 80 cycles. Expect: req_ready=4'b0100 for 1 cycle, tx_start 1 cycle later, tx_data=0xA5, grant_id=2, locked=0 throughout, state back in IDLE after tx_ready rises.
- Round-robin: all 4 requesters valid continuously, each byte last=1, data 0x10+i. Expect tx_data sequence 0x10,0x11,0x12,0x13,0x10 and exactly one tx_start per byte.
- Packet lock: requester 1 sends 0x01,0x02,0x03 (last on 0x03) while requester 0 and requester 3 are valid. Expect all three requester-1 bytes to go consecutively with locked=1 between them. Next grant is 3 (upward search from 1 skips to the next valid index, 3), then 0.
- Ack timeout: tx model never drops tx_ready after tx_start. Expect err_timeout=1 exactly 16 cycles after WAIT_ACK entry, still 1 afterwards, and the next request still arbitrated and transmitted normally.
- Transmitter busy: tx_ready=0 while requesters are valid. Expect req_ready=0 and no tx_start until tx_ready=1, then a grant in that same cycle.
- Reset mid-operation: assert reset during WAIT_DONE with locked=1. Expect all outputs at reset values on the next edge, and after release the first grant goes to requester 0 when all are valid.

Source files
------------

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between byte sources, the UART arbiter and the transmitter.
// The arbiter takes the slave side; the environment (sources + transmitter) the master side.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ   = 4,
  parameter int DATA_BITS = 8
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]           req_valid;
  logic [NUM_REQ*DATA_BITS-1:0] req_data;
  logic [NUM_REQ-1:0]           req_last;
  logic [NUM_REQ-1:0]           req_ready;
  logic                         tx_ready;
  logic                         tx_start;
  logic [DATA_BITS-1:0]         tx_data;
  logic [ID_W-1:0]              grant_id;
  logic                         locked;
  logic                         err_timeout;

  modport master (
    output req_valid, req_data, req_last, tx_ready,
    input  req_ready, tx_start, tx_data, grant_id, locked, err_timeout
  );

  modport slave (
    input  req_valid, req_data, req_last, tx_ready,
    output req_ready, tx_start, tx_data, grant_id, locked, err_timeout
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NUM_REQ byte sources,
// with packet lock and a sticky transmitter-acknowledge timeout flag.
module uart_tx_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_BITS   = 8,
  parameter int ACK_TIMEOUT = 16
) (
  input logic              clk,
  input logic              reset,
  uart_tx_arbiter_if.slave bus
);
  localparam int ID_W = $clog2(NUM_REQ);

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_START     = 3'd1;
  localparam logic [2:0] ST_WAIT_ACK  = 3'd2;
  localparam logic [2:0] ST_WAIT_DONE = 3'd3;
  localparam logic [2:0] ST_LOCKED    = 3'd4;

  localparam logic [7:0]      ACK_LIMIT = 8'(ACK_TIMEOUT);
  localparam logic [ID_W-1:0] PTR_INIT  = ID_W'(NUM_REQ - 1);

  logic [2:0]           state_r;
  logic [ID_W-1:0]      ptr_r;
  logic [ID_W-1:0]      grant_r;
  logic [DATA_BITS-1:0] tx_data_r;
  logic                 tx_start_r;
  logic                 locked_r;
  logic                 err_r;
  logic                 last_r;
  logic [7:0]           ack_cnt_r;

  logic [ID_W-1:0]      win_s;
  logic [ID_W-1:0]      sel_s;
  logic                 capture_s;
  logic [NUM_REQ-1:0]   ready_s;
  logic [DATA_BITS-1:0] sel_data_s;
  logic                 sel_last_s;
  logic [7:0]           ack_next_s;

  // First valid index searching upward from ptr+1, wrapping; ptr itself is checked last.
  function automatic logic [ID_W-1:0] rr_pick(input logic [NUM_REQ-1:0] valid,
                                              input logic [ID_W-1:0]    ptr);
    logic [ID_W-1:0] win;
    logic [ID_W-1:0] cand;
    logic            found;
    int              idx;
    win   = ptr;
    found = 1'b0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      idx  = (int'(ptr) + i) % NUM_REQ;
      cand = ID_W'(idx);
      if (!found && valid[cand]) begin
        win   = cand;
        found = 1'b1;
      end else begin
        found = found;
      end
    end
    return win;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [ID_W-1:0] idx);
    logic [NUM_REQ-1:0] v;
    v = {NUM_REQ{1'b0}};
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == idx) begin
        v[i] = 1'b1;
      end else begin
        v[i] = 1'b0;
      end
    end
    return v;
  endfunction

  // Decide whether a byte is accepted this cycle and from whom.
  always_comb begin
    win_s     = rr_pick(bus.req_valid, ptr_r);
    sel_s     = grant_r;
    capture_s = 1'b0;
    if (!reset) begin
      capture_s = 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          sel_s = win_s;
          if (bus.tx_ready && (|bus.req_valid)) begin
            capture_s = 1'b1;
          end else begin
            capture_s = 1'b0;
          end
        end
        ST_LOCKED: begin
          sel_s = grant_r;
          if (bus.tx_ready && bus.req_valid[grant_r]) begin
            capture_s = 1'b1;
          end else begin
            capture_s = 1'b0;
          end
        end
        default: begin
          sel_s     = grant_r;
          capture_s = 1'b0;
        end
      endcase
    end
  end

  // Steer the selected requester's byte and last marker toward the capture registers.
  always_comb begin
    sel_data_s = {DATA_BITS{1'b0}};
    sel_last_s = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (ID_W'(i) == sel_s) begin
        sel_data_s = bus.req_data[i*DATA_BITS +: DATA_BITS];
        sel_last_s = bus.req_last[i];
      end else begin
        sel_last_s = sel_last_s;
      end
    end
  end

  assign ready_s    = capture_s ? one_hot(sel_s) : {NUM_REQ{1'b0}};
  assign ack_next_s = ack_cnt_r + 8'd1;

  // Transmitter sequencing FSM with capture, lock and acknowledge timeout.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= PTR_INIT;
      grant_r    <= {ID_W{1'b0}};
      tx_data_r  <= {DATA_BITS{1'b0}};
      tx_start_r <= 1'b0;
      locked_r   <= 1'b0;
      err_r      <= 1'b0;
      last_r     <= 1'b0;
      ack_cnt_r  <= 8'd0;
    end else begin
      tx_start_r <= 1'b0;
      case (state_r)
        ST_IDLE, ST_LOCKED: begin
          if (capture_s) begin
            tx_data_r  <= sel_data_s;
            grant_r    <= sel_s;
            ptr_r      <= sel_s;
            last_r     <= sel_last_s;
            tx_start_r <= 1'b1;
            state_r    <= ST_START;
          end else begin
            state_r <= state_r;
          end
        end
        ST_START: begin
          ack_cnt_r <= 8'd0;
          state_r   <= ST_WAIT_ACK;
        end
        ST_WAIT_ACK: begin
          if (!bus.tx_ready) begin
            state_r <= ST_WAIT_DONE;
          end else begin
            ack_cnt_r <= ack_next_s;
            // Transmitter never went busy: drop the byte, keep the pointer.
            if (ack_next_s == ACK_LIMIT) begin
              err_r    <= 1'b1;
              locked_r <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              state_r <= ST_WAIT_ACK;
            end
          end
        end
        ST_WAIT_DONE: begin
          if (bus.tx_ready) begin
            if (last_r) begin
              locked_r <= 1'b0;
              state_r  <= ST_IDLE;
            end else begin
              locked_r <= 1'b1;
              state_r  <= ST_LOCKED;
            end
          end else begin
            state_r <= ST_WAIT_DONE;
          end
        end
        default: begin
          locked_r <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready   = ready_s;
  assign bus.tx_start    = tx_start_r;
  assign bus.tx_data     = tx_data_r;
  assign bus.grant_id    = grant_r;
  assign bus.locked      = locked_r;
  assign bus.err_timeout = err_r;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter: single byte, rotation, packet lock,
// ack timeout, busy transmitter and reset in the middle of a locked packet.
module tb_uart_tx_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;
  int   start_cnt = 0;
  int   base;
  int   bad;
  bit   ok;

  always #5 clk = ~clk;

  uart_tx_arbiter_if #(.NUM_REQ(4), .DATA_BITS(8)) bus ();

  uart_tx_arbiter #(.NUM_REQ(4), .DATA_BITS(8), .ACK_TIMEOUT(16)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (reset === 1'b1 && bus.tx_start === 1'b1) start_cnt++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string t);
    check({t, "_rst_ready"}, 32'(bus.req_ready), 32'd0);
    check({t, "_rst_start"}, 32'(bus.tx_start), 32'd0);
    check({t, "_rst_data"}, 32'(bus.tx_data), 32'd0);
    check({t, "_rst_grant"}, 32'(bus.grant_id), 32'd0);
    check({t, "_rst_locked"}, 32'(bus.locked), 32'd0);
    check({t, "_rst_err"}, 32'(bus.err_timeout), 32'd0);
  endtask

  task automatic wait_start(output bit found);
    found = 1'b0;
    for (int i = 0; i < 64; i++) begin
      if (bus.tx_start === 1'b1) begin
        found = 1'b1;
        break;
      end
      step();
    end
  endtask

  // Wait for one launch, check it, then play the transmitter: busy for 'busy' cycles.
  task automatic send_byte(input int busy, input string tag,
                           input logic [7:0] exp_d, input logic [1:0] exp_id);
    bit f;
    wait_start(f);
    check({tag, "_start"}, 32'(f), 32'd1);
    if (f) begin
      check({tag, "_data"}, 32'(bus.tx_data), 32'(exp_d));
      check({tag, "_grant"}, 32'(bus.grant_id), 32'(exp_id));
      step();
      bus.tx_ready = 1'b0;
      repeat (busy) step();
      bus.tx_ready = 1'b1;
    end
  endtask

  initial begin
    reset         = 1'b0;
    bus.req_valid = 4'b0000;
    bus.req_data  = 32'h0000_0000;
    bus.req_last  = 4'b0000;
    bus.tx_ready  = 1'b1;
    repeat (4) step();
    chk_reset("init");
    reset = 1'b1;
    step();

    // Single byte from requester 2
    bus.req_data[23:16] = 8'hA5;
    bus.req_last[2]     = 1'b1;
    bus.req_valid       = 4'b0100;
    #1;
    check("t1_ready", 32'(bus.req_ready), 32'h4);
    check("t1_nostart", 32'(bus.tx_start), 32'd0);
    step();
    check("t1_ready_off", 32'(bus.req_ready), 32'd0);
    check("t1_start", 32'(bus.tx_start), 32'd1);
    check("t1_data", 32'(bus.tx_data), 32'hA5);
    check("t1_grant", 32'(bus.grant_id), 32'd2);
    check("t1_locked", 32'(bus.locked), 32'd0);
    bus.req_valid = 4'b0000;
    step();
    check("t1_pulse", 32'(bus.tx_start), 32'd0);
    bus.tx_ready = 1'b0;
    bad = 0;
    repeat (80) begin
      step();
      if (bus.locked !== 1'b0 || bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) bad++;
    end
    check("t1_busy_quiet", 32'(bad), 32'd0);
    bus.tx_ready = 1'b1;
    step();
    check("t1_unlocked", 32'(bus.locked), 32'd0);
    check("t1_data_hold", 32'(bus.tx_data), 32'hA5);
    check("t1_one_start", 32'(start_cnt), 32'd1);

    // Round-robin with every requester valid
    reset = 1'b0;
    step();
    step();
    reset         = 1'b1;
    bus.req_data  = 32'h1312_1110;
    bus.req_last  = 4'b1111;
    bus.req_valid = 4'b1111;
    base          = start_cnt;
    send_byte(3, "rr0", 8'h10, 2'd0);
    send_byte(3, "rr1", 8'h11, 2'd1);
    send_byte(3, "rr2", 8'h12, 2'd2);
    send_byte(3, "rr3", 8'h13, 2'd3);
    send_byte(3, "rr4", 8'h10, 2'd0);
    check("rr_starts", 32'(start_cnt - base), 32'd5);
    bus.req_valid = 4'b0000;
    step();

    // Packet lock: requester 1 sends three bytes while 0 and 3 wait
    bus.req_data  = 32'h2300_0120;
    bus.req_last  = 4'b1001;
    bus.req_valid = 4'b1011;
    base          = start_cnt;
    send_byte(3, "lk0", 8'h01, 2'd1);
    bus.req_data[15:8] = 8'h02;
    step();
    check("lk_locked0", 32'(bus.locked), 32'd1);
    check("lk_ready0", 32'(bus.req_ready), 32'h2);
    send_byte(3, "lk1", 8'h02, 2'd1);
    bus.req_data[15:8] = 8'h03;
    bus.req_last[1]    = 1'b1;
    step();
    check("lk_locked1", 32'(bus.locked), 32'd1);
    send_byte(3, "lk2", 8'h03, 2'd1);
    bus.req_valid[1] = 1'b0;
    step();
    check("lk_unlock", 32'(bus.locked), 32'd0);
    send_byte(3, "lk3", 8'h23, 2'd3);
    bus.req_valid[3] = 1'b0;
    send_byte(3, "lk4", 8'h20, 2'd0);
    bus.req_valid[0] = 1'b0;
    check("lk_starts", 32'(start_cnt - base), 32'd5);
    step();

    // Ack timeout: transmitter never goes busy
    bus.req_data[23:16] = 8'h5C;
    bus.req_last[2]     = 1'b1;
    bus.req_valid       = 4'b0100;
    base                = start_cnt;
    wait_start(ok);
    check("to_start", 32'(ok), 32'd1);
    check("to_grant", 32'(bus.grant_id), 32'd2);
    bus.req_valid[2] = 1'b0;
    repeat (16) step();
    check("to_err_early", 32'(bus.err_timeout), 32'd0);
    step();
    check("to_err", 32'(bus.err_timeout), 32'd1);
    check("to_unlock", 32'(bus.locked), 32'd0);
    repeat (4) step();
    check("to_sticky", 32'(bus.err_timeout), 32'd1);
    check("to_one_start", 32'(start_cnt - base), 32'd1);
    bus.req_data[15:8] = 8'h77;
    bus.req_last[1]    = 1'b1;
    bus.req_valid[1]   = 1'b1;
    send_byte(3, "to_next", 8'h77, 2'd1);
    bus.req_valid[1] = 1'b0;
    check("to_sticky2", 32'(bus.err_timeout), 32'd1);
    step();

    // Transmitter busy while everybody is valid (packets left open)
    bus.tx_ready  = 1'b0;
    bus.req_data  = 32'h3332_3130;
    bus.req_last  = 4'b0000;
    bus.req_valid = 4'b1111;
    bad = 0;
    repeat (5) begin
      step();
      if (bus.req_ready !== 4'b0000 || bus.tx_start !== 1'b0) bad++;
    end
    check("bz_hold", 32'(bad), 32'd0);
    bus.tx_ready = 1'b1;
    #1;
    check("bz_ready", 32'(bus.req_ready), 32'h4);
    step();
    check("bz_start", 32'(bus.tx_start), 32'd1);
    check("bz_data", 32'(bus.tx_data), 32'h32);

    // Reset during WAIT_DONE of a locked packet
    step();
    bus.tx_ready = 1'b0;
    step();
    bus.tx_ready = 1'b1;
    step();
    check("rs_locked", 32'(bus.locked), 32'd1);
    check("rs_lock_ready", 32'(bus.req_ready), 32'h4);
    step();
    step();
    bus.tx_ready = 1'b0;
    step();
    check("rs_locked2", 32'(bus.locked), 32'd1);
    reset        = 1'b0;
    bus.tx_ready = 1'b1;
    step();
    chk_reset("mid");
    reset = 1'b1;
    #1;
    check("rs_first_ready", 32'(bus.req_ready), 32'h1);
    step();
    check("rs_first_start", 32'(bus.tx_start), 32'd1);
    check("rs_first_grant", 32'(bus.grant_id), 32'd0);
    check("rs_first_data", 32'(bus.tx_data), 32'h30);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
